// File: rtl/bus_pkg.sv
//------------------------------------------------------------------------------
// Module      : bus_pkg
// Description : Shared state encoding, address map defaults and status bits
//               for the bus_slave responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   localparam int unsigned c_MEM_AW   = 13;
   localparam logic [12:0] c_RAM_BASE = 13'h1800;
   localparam logic [12:0] c_IO_STAT  = 13'h1FFE;
   localparam logic [12:0] c_IO_OUT   = 13'h1FFF;

   // Bit positions inside the status register
   localparam int unsigned c_STAT_ERR_BIT = 1;
   localparam int unsigned c_STAT_OV_BIT  = 0;

endpackage

`default_nettype wire

// File: rtl/bus_if.sv
//------------------------------------------------------------------------------
// Module      : bus_if
// Description : CPU strobes/address, loader port and output-port handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bus_if #(
   parameter int unsigned AW = bus_pkg::c_MEM_AW
) ();

   logic          rd;
   logic          wr;
   logic [AW-1:0] addr;
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [7:0]    ld_data;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ack;
   logic          err;

   modport master (
      output rd, wr, addr, ld_en, ld_addr, ld_data, out_ack,
      input  out_data, out_valid, err
   );

   modport slave (
      input  rd, wr, addr, ld_en, ld_addr, ld_data, out_ack,
      output out_data, out_valid, err
   );

endinterface

`default_nettype wire

// File: rtl/bus_mem.sv
//------------------------------------------------------------------------------
// Module      : bus_mem
// Description : Single-port synchronous byte RAM with registered read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_mem #(
   parameter int unsigned AW = 13
) (
   input  logic          clk,
   input  logic          i_en,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [7:0]    i_wdata,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [0:(1<<AW)-1];
   logic [7:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_wdata;
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/bus_slave.sv
//------------------------------------------------------------------------------
// Module      : bus_slave
// Description : Memory/I-O responder: CPU read/write FSM, output port,
//               status register, loader path and shared-bus driver.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_slave
   import bus_pkg::*;
#(
   parameter int unsigned         MEM_AW   = c_MEM_AW,
   parameter logic [MEM_AW-1:0]   RAM_BASE = c_RAM_BASE,
   parameter logic [MEM_AW-1:0]   IO_STAT  = c_IO_STAT,
   parameter logic [MEM_AW-1:0]   IO_OUT   = c_IO_OUT
) (
   input  logic     clk,
   input  logic     reset,
   bus_if.slave     bus,
   inout  wire [7:0] data
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_rd_q;
   logic              r_wr_q;
   logic              r_drv;
   logic [MEM_AW-1:0] r_addr;
   logic [7:0]        r_wbuf;
   logic [7:0]        r_out_data;
   logic              r_out_valid;
   logic              r_err;

   logic w_rd_rise;
   logic w_wr_rise;
   logic w_accept_rd;
   logic w_accept_wr;
   logic w_sample;
   logic w_release;
   logic w_commit;
   logic w_set_err;
   logic w_ld_ok;

   assign w_rd_rise = bus.rd & ~r_rd_q;
   assign w_wr_rise = bus.wr & ~r_wr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept_rd = 1'b0;
      w_accept_wr = 1'b0;
      w_sample    = 1'b0;
      w_release   = 1'b0;
      w_commit    = 1'b0;
      w_set_err   = 1'b0;
      w_ld_ok     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.rd && bus.wr) begin
               w_state_nxt = ST_ERR;
               w_set_err   = 1'b1;
            end else if (bus.rd && !r_rd_q) begin
               w_state_nxt = ST_READ;
               w_accept_rd = 1'b1;
            end else if (bus.wr && !r_wr_q) begin
               w_state_nxt = ST_WRITE;
               w_accept_wr = 1'b1;
               w_sample    = 1'b1;
            end else if (!bus.rd && !bus.wr) begin
               w_ld_ok = bus.ld_en && (bus.ld_addr != IO_STAT) && (bus.ld_addr != IO_OUT);
            end
         end
         ST_READ: begin
            if (w_wr_rise) begin
               w_state_nxt = ST_ERR;
               w_set_err   = 1'b1;
               w_release   = 1'b1;
            end else if (!bus.rd) begin
               w_state_nxt = ST_IDLE;
               w_release   = 1'b1;
            end
         end
         ST_WRITE: begin
            if (w_rd_rise) begin
               w_state_nxt = ST_ERR;
               w_set_err   = 1'b1;
            end else if (!bus.wr) begin
               w_state_nxt = ST_IDLE;
               w_commit    = 1'b1;
            end else begin
               w_sample = 1'b1;
            end
         end
         ST_ERR: begin
            if (!bus.rd && !bus.wr) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Commit decode; I/O addresses shadow the array
   logic w_is_stat;
   logic w_is_out;
   logic w_is_ram;
   logic w_ov_eff;
   logic w_mem_cpu_we;
   logic w_out_load;
   logic w_commit_err;

   assign w_is_stat    = (r_addr == IO_STAT);
   assign w_is_out     = (r_addr == IO_OUT);
   assign w_is_ram     = (r_addr >= RAM_BASE) && !w_is_stat && !w_is_out;
   assign w_ov_eff     = r_out_valid & ~bus.out_ack;
   assign w_mem_cpu_we = w_commit & w_is_ram;
   assign w_out_load   = w_commit & w_is_out & ~w_ov_eff;
   assign w_commit_err = w_commit & ((w_is_out & w_ov_eff) | (!w_is_out & !w_is_ram));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_q      <= 1'b0;
         r_wr_q      <= 1'b0;
         r_drv       <= 1'b0;
         r_addr      <= '0;
         r_wbuf      <= 8'h00;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_rd_q <= bus.rd;
         r_wr_q <= bus.wr;
         if (w_accept_rd || w_accept_wr) begin
            r_addr <= bus.addr;
         end
         if (w_accept_rd) begin
            r_drv <= 1'b1;
         end else if (w_release) begin
            r_drv <= 1'b0;
         end
         if (w_sample) begin
            r_wbuf <= data;
         end
         if (w_set_err || w_commit_err) begin
            r_err <= 1'b1;
         end
         // Ack is applied before a same-edge commit to the output port
         if (w_out_load) begin
            r_out_data  <= r_wbuf;
            r_out_valid <= 1'b1;
         end else if (bus.out_ack) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   logic              w_mem_en;
   logic              w_mem_we;
   logic [MEM_AW-1:0] w_mem_addr;
   logic [7:0]        w_mem_wdata;
   logic [7:0]        w_mem_rdata;

   assign w_mem_we    = w_mem_cpu_we | w_ld_ok;
   assign w_mem_en    = w_mem_we | w_accept_rd;
   assign w_mem_addr  = w_ld_ok ? bus.ld_addr : (w_accept_rd ? bus.addr : r_addr);
   assign w_mem_wdata = w_ld_ok ? bus.ld_data : r_wbuf;

   bus_mem #(
      .AW (MEM_AW)
   ) u_mem (
      .clk     (clk),
      .i_en    (w_mem_en),
      .i_we    (w_mem_we),
      .i_addr  (w_mem_addr),
      .i_wdata (w_mem_wdata),
      .o_rdata (w_mem_rdata)
   );

   logic [7:0] w_status;
   logic [7:0] w_rd_val;

   always_comb begin
      w_status                 = 8'h00;
      w_status[c_STAT_ERR_BIT] = r_err;
      w_status[c_STAT_OV_BIT]  = r_out_valid;
      if (w_is_stat) begin
         w_rd_val = w_status;
      end else if (w_is_out) begin
         w_rd_val = 8'h00;
      end else begin
         w_rd_val = w_mem_rdata;
      end
   end

   assign data          = r_drv ? w_rd_val : 8'hzz;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: doc/bus_slave.md
# bus_slave

Memory/I-O responder on the far end of the CPU's rd/wr/addr/data bus. Holds program and data memory in one synchronous array, answers CPU reads by driving the shared 8-bit bus, and commits CPU writes to the RAM region or to a handshaked output port. A loader port fills memory while the CPU is held in reset.

## Interface
- `MEM_AW`, 13: memory address width; array depth is 2^MEM_AW bytes.
- `RAM_BASE`, 13'h1800: addresses below this are read-only to the CPU (program region); addresses at or above it are read/write.
- `IO_STAT`, 13'h1FFE: status register address; read-only.
- `IO_OUT`, 13'h1FFF: output port register address; write-only.
- `clk`  in  1  system clock, the same clock as the CPU's `clk`. Every event is on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rd`  in  1  CPU read strobe, synchronous to `clk`.
- `wr`  in  1  CPU write strobe, synchronous to `clk`.
- `addr`  in  13  CPU address.
- `data`  inout  8  shared bus. Driven only in READ with `drv`=1; otherwise high-Z.
- `ld_en`  in  1  loader write enable.
- `ld_addr`  in  13  loader address.
- `ld_data`  in  8  loader data.
- `out_data`  out  8  output port value.
- `out_valid`  out  1  output port holds unconsumed data.
- `out_ack`  in  1  consumer accepts `out_data`; clears `out_valid`.
- `err`  out  1  sticky protocol/access error.

## Operation
- FSM states: IDLE, READ, WRITE, ERR. `rd_q`/`wr_q` hold the registered strobes for edge detection.
- IDLE:
  - `rd`=1, `wr`=0, `rd_q`=0: latch `addr` and go to READ.
  - `wr`=1, `rd`=0, `wr_q`=0: latch `addr` and go to WRITE.
  - `rd`=`wr`=1: go to ERR and set `err`.
- READ, data source:
  - At `IO_STAT`: drive {6'b0, `err`, `out_valid`}.
  - At `IO_OUT`: drive 8'h00.
  - Otherwise: drive mem[latched addr].
- READ, control:
  - Set `drv` at the entry edge.
  - Hold `drv` while `rd`=1.
  - At the first edge with `rd`=0, clear `drv` and return to IDLE.
  - If `wr` rises during READ: set `err`, release the bus, go to ERR.
- WRITE:
  - Sample `data` into `wbuf` on every edge with `wr`=1.
  - At the first edge with `wr`=0, commit `wbuf` and return to IDLE.
  - A rise of `rd` during WRITE sets `err`, aborts the write (nothing committed) and goes to ERR.
- Commit targets:
  - addr ≥ `RAM_BASE` and not an I/O address: mem[addr] ← `wbuf`.
  - addr = `IO_OUT` with `out_valid`=0: `out_data` ← `wbuf` and `out_valid` ← 1.
  - addr = `IO_OUT` with `out_valid`=1: data dropped, `err` ← 1.
  - addr < `RAM_BASE` or addr = `IO_STAT`: ignored, `err` ← 1.
- ERR: leave for IDLE at the first edge with `rd`=`wr`=0. No drive and no commits while in ERR.
- I/O addresses take priority over the memory array.
- Loader: accepted only in IDLE with `rd`=`wr`=0. Writes any address, including the program region; I/O addresses are ignored. `ld_en` in any other state is ignored silently and does not set `err`.
- `out_ack` clears `out_valid` at the next edge. If the ack and a commit to `IO_OUT` arrive in the same edge, the ack is applied first, so the new value is accepted and `out_valid` stays 1.
- `err` clears only on `reset`.

## Timing
- Reset values: state IDLE, `drv`=0 (`data` high-Z), `out_data`=8'h00, `out_valid`=0, `err`=0, `rd_q`=`wr_q`=0, `wbuf`=0. Memory contents are not reset.
- Read latency: `rd` sampled high at edge k → `data` valid after edge k (synchronous array read at edge k), held until edge j, the first edge with `rd`=0. High-Z after edge j.
- Write commit: at edge j, the first with `wr`=0. The value committed is the one sampled at edge j-1.
- Loader write: memory is updated at the same edge.
- Back-to-back accesses: after returning to IDLE at edge j, a new strobe rise is accepted from edge j+1. A strobe already high when IDLE is re-entered is not a new edge and is ignored.
- `reset` asserted mid-access: bus released immediately (asynchronously), any pending write discarded.

## Structure
- Package `bus_pkg`: state encoding, the `RAM_BASE`/`IO_STAT`/`IO_OUT` default constants, and the status bit positions (bit1 `err`, bit0 `out_valid`).
- Sub-module `bus_mem`: single-port synchronous RAM, 2^MEM_AW × 8, registered read, write-enable muxed between the CPU commit and the loader.
- The FSM, I/O registers and tri-state driver live in `bus_slave`.

## Test plan
- Loader writes 8'hA5 to 13'h0010, then the CPU reads 13'h0010 → `data`=8'hA5 one edge after `rd` rises, high-Z at the first edge after `rd` falls.
- CPU writes 8'h3C to 13'h1800 with `wr` held 3 cycles, then reads 13'h1800 → 8'h3C. A write of 8'h11 to 13'h0010 leaves 8'hA5 in place and sets `err`=1.
- Write 8'h42 to `IO_OUT` → `out_data`=8'h42, `out_valid`=1. A second write of 8'h43 before `out_ack` → dropped, `err`=1. After `out_ack`, read `IO_STAT` → 8'h02.
- `rd` and `wr` rise together → no drive, no commit, `err`=1. Return to IDLE once both are low, then a normal read succeeds.
- `reset` pulsed mid-write to 13'h1900 (old 8'h00, new 8'hFF) → memory keeps 8'h00, `data` high-Z immediately, all outputs at reset values.
- `ld_en` asserted during READ → ignored: memory unchanged and `err` unchanged.
